// File: rtl/switcher_matrix.sv
// switcher_matrix: serial-configured router steering each input line to one of 2^SEL_W outputs.
// A frame is committed to the active routing only when it carries exactly FRAME bits.
module switcher_matrix #(
    parameter int CHANNELS = 8,
    parameter int SEL_W = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sda,
    input  logic                             sen,
    input  logic [CHANNELS-1:0]              lines_in,
    output logic [CHANNELS*(1<<SEL_W)-1:0]   lines_out,
    output logic                             busy,
    output logic                             load_done,
    output logic                             frame_err
);
    localparam int K = 1 << SEL_W;
    localparam int FRAME = CHANNELS * SEL_W;
    localparam int CW = $clog2(FRAME + 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nx;
    logic [FRAME-1:0] shadow, shadow_nx, active, active_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic load_nx, err_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            active    <= '0;
            cnt       <= '0;
            load_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            shadow    <= shadow_nx;
            active    <= active_nx;
            cnt       <= cnt_nx;
            load_done <= load_nx;
            frame_err <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        shadow_nx = sen ? FRAME'({shadow, sda}) : shadow;
        active_nx = active;
        cnt_nx    = cnt;
        load_nx   = 1'b0;
        err_nx    = 1'b0;
        if (state == IDLE) begin
            if (sen) begin
                cnt_nx   = CW'(1);
                state_nx = SHIFT;
            end
        end else if (sen) begin
            cnt_nx = (cnt == CW'(FRAME + 1)) ? cnt : cnt + 1'b1;
        end else begin
            // Only an exact-length frame reaches the outputs; anything else is dropped whole.
            active_nx = (cnt == CW'(FRAME)) ? shadow : active;
            load_nx   = (cnt == CW'(FRAME));
            err_nx    = (cnt != CW'(FRAME));
            cnt_nx    = '0;
            state_nx  = IDLE;
        end
    end

    assign busy = (state == SHIFT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        for (genvar j = 0; j < K; j++) begin : g_out
            assign lines_out[i*K+j] = lines_in[i] & (active[i*SEL_W +: SEL_W] == SEL_W'(j));
        end
    end
endmodule

// File: tb/tb_switcher_matrix.sv
// tb_switcher_matrix: directed bench for two switcher_matrix instances (SEL_W=2 and SEL_W=1),
// checked every cycle against a frame-level routing model plus literal expectations.
module tb_switcher_matrix;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sen = 2'b00;
    logic [1:0]  sda = 2'b00;
    logic [7:0]  lines_in = 8'hFF;
    logic [31:0] out2;
    logic [15:0] out1;
    logic [1:0]  busy, load_done, frame_err;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    int loads2 = 0;

    logic [31:0] m_cfg[2];
    logic [31:0] m_sh[2];
    int          m_cnt[2];
    logic        m_busy[2], m_ld[2], m_er[2];

    always #5 clk = ~clk;

    switcher_matrix #(.CHANNELS(8), .SEL_W(2)) dut2 (
        .clk(clk), .reset(reset), .sda(sda[0]), .sen(sen[0]), .lines_in(lines_in),
        .lines_out(out2), .busy(busy[0]), .load_done(load_done[0]), .frame_err(frame_err[0])
    );

    switcher_matrix #(.CHANNELS(8), .SEL_W(1)) dut1 (
        .clk(clk), .reset(reset), .sda(sda[1]), .sen(sen[1]), .lines_in(lines_in),
        .lines_out(out1), .busy(busy[1]), .load_done(load_done[1]), .frame_err(frame_err[1])
    );

    function automatic int sel_w(input int d);
        return d == 0 ? 2 : 1;
    endfunction

    // Expected routed word: each set input bit lands at its group base plus its select value.
    function automatic logic [31:0] route(input logic [31:0] cfg, input logic [7:0] li, input int sw);
        logic [31:0] r;
        int k, s;
        r = '0;
        k = 1 << sw;
        for (int i = 0; i < 8; i++) begin
            s = int'((cfg >> (i * sw)) & 32'(k - 1));
            if (li[i]) r[i*k+s] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_cfg[d] <= '0; m_sh[d] <= '0; m_cnt[d] <= 0;
                m_busy[d] <= 1'b0; m_ld[d] <= 1'b0; m_er[d] <= 1'b0;
            end else begin
                m_ld[d] <= 1'b0;
                m_er[d] <= 1'b0;
                if (sen[d]) begin
                    m_sh[d] <= (m_sh[d] << 1) | 32'(sda[d]);
                    m_cnt[d] <= m_cnt[d] + 1;
                    m_busy[d] <= 1'b1;
                end else if (m_busy[d]) begin
                    if (m_cnt[d] == 8 * sel_w(d)) begin
                        m_cfg[d] <= m_sh[d];
                        m_ld[d] <= 1'b1;
                    end else begin
                        m_er[d] <= 1'b1;
                    end
                    m_sh[d] <= '0;
                    m_cnt[d] <= 0;
                    m_busy[d] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out2", out2, route(m_cfg[0], lines_in, 2));
            chk("busy2", 32'(busy[0]), 32'(m_busy[0]));
            chk("load_done2", 32'(load_done[0]), 32'(m_ld[0]));
            chk("frame_err2", 32'(frame_err[0]), 32'(m_er[0]));
            chk("out1", 32'(out1), route(m_cfg[1], lines_in, 1));
            chk("busy1", 32'(busy[1]), 32'(m_busy[1]));
            chk("load_done1", 32'(load_done[1]), 32'(m_ld[1]));
            chk("frame_err1", 32'(frame_err[1]), 32'(m_er[1]));
            if (load_done[0]) loads2++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input int d, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sen[d] = 1'b1;
            sda[d] = v[i];
            tick();
        end
    endtask

    task automatic send(input int d, input logic [31:0] v, input int n);
        shift_bits(d, v, n);
        sen[d] = 1'b0;
        sda[d] = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        started = 1;
        chk("lit_reset_out2", out2, 32'h11111111);
        chk("lit_reset_flags", {29'd0, busy[0], load_done[0], frame_err[0]}, 32'd0);
        tick();

        send(0, 32'h8001, 16);
        chk("lit_commit_out2", out2, 32'h41111112);
        chk("lit_commit_pulse", 32'(load_done[0]), 32'd1);
        tick();

        send(0, 32'hFFFF >> 1, 15);
        chk("lit_short_err", 32'(frame_err[0]), 32'd1);
        tick();
        send(0, 32'h1FFFF, 17);
        chk("lit_long_err", 32'(frame_err[0]), 32'd1);
        chk("lit_long_out2", out2, 32'h41111112);
        tick();

        send(1, 32'hA5, 8);
        lines_in = 8'h0F;
        #1;
        chk("lit_sel1_out1", 32'(out1), 32'h0066);
        tick();
        lines_in = 8'hFF;
        tick();

        shift_bits(0, 32'h1FF, 9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sen[0] = 1'b0;
        tick();
        chk("lit_abort_out2", out2, 32'h11111111);
        chk("lit_abort_flags", {29'd0, busy[0], load_done[0], frame_err[0]}, 32'd0);

        loads2 = 0;
        send(0, 32'h1234, 16);
        send(0, 32'hC3A5, 16);
        tick();
        chk("lit_b2b_loads", 32'(loads2), 32'd2);
        chk("lit_b2b_out2", out2, 32'h81184422);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
